// File: rtl/decode_queue.sv
// RV32I decode stage: DEPTH-entry instruction queue feeding a registered decode bundle.
// Optional macro DECODE_MEXT_EN adds MUL/MULH/DIV/REM decoding for R-type funct7=0000001.
module decode_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [6:0]       opcode,
    output logic [2:0]       funct3,
    output logic [6:0]       funct7,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic [31:0]      imm,
    output logic [3:0]       alu_op,
    output logic [7:0]       ctrl,
    output logic             illegal,
    output logic             flush_cs,
    output logic [CNT_W-1:0] occupancy
);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [3:0] ALU_NONE = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_SLL  = 4'd3;
    localparam logic [3:0] ALU_SLT  = 4'd4;
    localparam logic [3:0] ALU_SLTU = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_OR   = 4'd9;
    localparam logic [3:0] ALU_AND  = 4'd10;
    localparam logic [3:0] ALU_ADDI = 4'd11;
`ifdef DECODE_MEXT_EN
    localparam logic [3:0] ALU_MUL  = 4'd12;
    localparam logic [3:0] ALU_MULH = 4'd13;
    localparam logic [3:0] ALU_DIV  = 4'd14;
    localparam logic [3:0] ALU_REM  = 4'd15;
`endif

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [31:0]      r_instr_mem [DEPTH];
    logic [XLEN-1:0]  r_pc_mem    [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             r_out_valid;
    logic [XLEN-1:0]  r_out_pc;
    logic [6:0]       r_opcode;
    logic [2:0]       r_funct3;
    logic [6:0]       r_funct7;
    logic [4:0]       r_rs1;
    logic [4:0]       r_rs2;
    logic [4:0]       r_rd;
    logic [31:0]      r_imm;
    logic [3:0]       r_alu_op;
    logic [7:0]       r_ctrl;
    logic             r_illegal;
    logic             r_flush_cs;

    logic [31:0] w_head;
    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u, w_imm_sh;
    logic        w_illegal;
    logic        w_jump;
    logic [3:0]  w_alu;
    logic [7:0]  w_ctrl;
    logic [31:0] w_imm;
    logic [4:0]  w_rs1;
    logic        w_full, w_empty, w_load, w_self_flush, w_push, w_pop;

    assign w_head   = r_instr_mem[r_rd_ptr];
    assign w_opc    = w_head[6:0];
    assign w_f3     = w_head[14:12];
    assign w_f7     = w_head[31:25];
    assign w_imm_i  = {{20{w_head[31]}}, w_head[31:20]};
    assign w_imm_s  = {{20{w_head[31]}}, w_head[31:25], w_head[11:7]};
    assign w_imm_b  = {{19{w_head[31]}}, w_head[31], w_head[7], w_head[30:25], w_head[11:8], 1'b0};
    assign w_imm_j  = {{11{w_head[31]}}, w_head[31], w_head[19:12], w_head[20], w_head[30:21], 1'b0};
    assign w_imm_u  = {w_head[31:12], 12'b0};
    assign w_imm_sh = {27'b0, w_head[24:20]};

    // Decode of the queue head; illegal encodings collapse to an all-zero control bundle.
    always_comb begin
        w_illegal = 1'b0;
        w_jump    = 1'b0;
        w_alu     = ALU_NONE;
        w_ctrl    = 8'h00;
        w_imm     = 32'h0;
        w_rs1     = w_head[19:15];
        case (w_opc)
            OPC_LUI: begin
                w_rs1  = 5'd0;
                w_alu  = ALU_ADDI;
                w_ctrl = 8'h03;
                w_imm  = w_imm_u;
            end
            OPC_AUIPC: begin
                w_alu  = ALU_ADDI;
                w_ctrl = 8'h03;
                w_imm  = w_imm_u;
            end
            OPC_JAL: begin
                w_jump = 1'b1;
                w_ctrl = 8'h41;
                w_imm  = w_imm_j;
            end
            OPC_JALR: begin
                w_jump    = 1'b1;
                w_alu     = ALU_ADDI;
                w_ctrl    = 8'hC3;
                w_imm     = w_imm_i;
                w_illegal = (w_f3 != 3'b000);
            end
            OPC_BRANCH: begin
                w_ctrl    = 8'h20;
                w_imm     = w_imm_b;
                w_illegal = (w_f3 == 3'b010) || (w_f3 == 3'b011);
            end
            OPC_LOAD: begin
                w_alu     = ALU_ADDI;
                w_ctrl    = 8'h0F;
                w_imm     = w_imm_i;
                w_illegal = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
            end
            OPC_STORE: begin
                w_alu     = ALU_ADDI;
                w_ctrl    = 8'h12;
                w_imm     = w_imm_s;
                w_illegal = (w_f3 > 3'b010);
            end
            OPC_OPIMM: begin
                w_ctrl = 8'h03;
                w_imm  = w_imm_i;
                case (w_f3)
                    3'b000: w_alu = ALU_ADDI;
                    3'b010: w_alu = ALU_SLT;
                    3'b011: w_alu = ALU_SLTU;
                    3'b100: w_alu = ALU_XOR;
                    3'b110: w_alu = ALU_OR;
                    3'b111: w_alu = ALU_AND;
                    3'b001: begin
                        w_alu     = ALU_SLL;
                        w_imm     = w_imm_sh;
                        w_illegal = (w_f7 != 7'b0000000);
                    end
                    default: begin
                        w_alu     = w_f7[5] ? ALU_SRA : ALU_SRL;
                        w_imm     = w_imm_sh;
                        w_illegal = (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000);
                    end
                endcase
            end
            OPC_OP: begin
                w_ctrl = 8'h01;
                if (w_f7 == 7'b0000000) begin
                    case (w_f3)
                        3'b000:  w_alu = ALU_ADD;
                        3'b001:  w_alu = ALU_SLL;
                        3'b010:  w_alu = ALU_SLT;
                        3'b011:  w_alu = ALU_SLTU;
                        3'b100:  w_alu = ALU_XOR;
                        3'b101:  w_alu = ALU_SRL;
                        3'b110:  w_alu = ALU_OR;
                        default: w_alu = ALU_AND;
                    endcase
                end else if (w_f7 == 7'b0100000) begin
                    w_alu     = (w_f3 == 3'b000) ? ALU_SUB : ALU_SRA;
                    w_illegal = (w_f3 != 3'b000) && (w_f3 != 3'b101);
                end else if (w_f7 == 7'b0000001) begin
`ifdef DECODE_MEXT_EN
                    case (w_f3)
                        3'b000:  w_alu = ALU_MUL;
                        3'b001:  w_alu = ALU_MULH;
                        3'b100:  w_alu = ALU_DIV;
                        3'b110:  w_alu = ALU_REM;
                        default: w_illegal = 1'b1;
                    endcase
`else
                    w_illegal = 1'b1;
`endif
                end else begin
                    w_illegal = 1'b1;
                end
            end
            default: w_illegal = 1'b1;
        endcase
        if (w_illegal) begin
            w_jump = 1'b0;
            w_alu  = ALU_NONE;
            w_ctrl = 8'h00;
            w_imm  = 32'h0;
        end
    end

    // A full queue refuses input even when the head leaves the same cycle.
    assign w_full       = (r_count == CNT_W'(DEPTH));
    assign w_empty      = (r_count == '0);
    assign in_ready     = rst_n & ~w_full;
    assign w_load       = ~w_empty & (~r_out_valid | out_ready);
    assign w_self_flush = w_load & w_jump;
    assign w_push       = in_valid & in_ready & ~flush & ~w_self_flush;
    assign w_pop        = w_load & ~flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr_mem[r_wr_ptr] <= in_instr;
            r_pc_mem[r_wr_ptr]    <= in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush || w_self_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_pc    <= '0;
            r_opcode    <= '0;
            r_funct3    <= '0;
            r_funct7    <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_imm       <= '0;
            r_alu_op    <= '0;
            r_ctrl      <= '0;
            r_illegal   <= 1'b0;
            r_flush_cs  <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_pc    <= r_pc_mem[r_rd_ptr];
            r_opcode    <= w_opc;
            r_funct3    <= w_f3;
            r_funct7    <= w_f7;
            r_rs1       <= w_rs1;
            r_rs2       <= w_head[24:20];
            r_rd        <= w_head[11:7];
            r_imm       <= w_imm;
            r_alu_op    <= w_alu;
            r_ctrl      <= w_ctrl;
            r_illegal   <= w_illegal;
            r_flush_cs  <= w_jump;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_pc    = r_out_pc;
    assign opcode    = r_opcode;
    assign funct3    = r_funct3;
    assign funct7    = r_funct7;
    assign rs1       = r_rs1;
    assign rs2       = r_rs2;
    assign rd        = r_rd;
    assign imm       = r_imm;
    assign alu_op    = r_alu_op;
    assign ctrl      = r_ctrl;
    assign illegal   = r_illegal;
    assign flush_cs  = r_flush_cs;
    assign occupancy = r_count;
endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: directed scenarios plus randomized traffic against a queue-based reference.
module tb_decode_queue;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [3:0] A_ADD = 4'd1, A_SUB = 4'd2, A_SLL = 4'd3, A_SRL = 4'd7, A_SRA = 4'd8, A_ADDI = 4'd11;
    localparam logic [3:0] OP_ALU [8] = '{4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10};
    localparam logic [6:0] OPCS [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

    logic             clk = 1'b0;
    logic             rst_n, in_valid, flush, out_ready;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_pc;
    logic             in_ready, out_valid, illegal, flush_cs;
    logic [XLEN-1:0]  out_pc;
    logic [6:0]       opcode, funct7;
    logic [2:0]       funct3;
    logic [4:0]       rs1, rs2, rd;
    logic [31:0]      imm;
    logic [3:0]       alu_op;
    logic [7:0]       ctrl;
    logic [CNT_W-1:0] occupancy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        ill;
        logic        fcs;
        logic [3:0]  alu;
        logic [7:0]  ctrl;
        logic [31:0] imm;
        logic [4:0]  rs1;
    } dec_t;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } ent_t;

    ent_t q[$];
    logic m_valid;
    logic m_zero;
    ent_t m_ent;

    decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .alu_op(alu_op), .ctrl(ctrl),
        .illegal(illegal), .flush_cs(flush_cs), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Reference decode straight from the RV32I instruction tables.
    function automatic dec_t ref_decode(input logic [31:0] i);
        dec_t d;
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic [31:0] shamt;
        op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
        shamt = {27'b0, i[24:20]};
        d = '0;
        d.rs1 = i[19:15];
        d.ill = 1'b1;
        case (op)
            7'h37: begin d.ill = 0; d.rs1 = 0; d.alu = A_ADDI; d.ctrl = 8'h03; d.imm = {i[31:12], 12'b0}; end
            7'h17: begin d.ill = 0; d.alu = A_ADDI; d.ctrl = 8'h03; d.imm = {i[31:12], 12'b0}; end
            7'h6F: begin
                d.ill = 0; d.fcs = 1; d.ctrl = 8'h41;
                d.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            end
            7'h67: if (f3 == 0) begin
                d.ill = 0; d.fcs = 1; d.alu = A_ADDI; d.ctrl = 8'hC3; d.imm = {{20{i[31]}}, i[31:20]};
            end
            7'h63: if (f3 != 2 && f3 != 3) begin
                d.ill = 0; d.ctrl = 8'h20;
                d.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            end
            7'h03: if (f3 inside {0, 1, 2, 4, 5}) begin
                d.ill = 0; d.alu = A_ADDI; d.ctrl = 8'h0F; d.imm = {{20{i[31]}}, i[31:20]};
            end
            7'h23: if (f3 <= 2) begin
                d.ill = 0; d.alu = A_ADDI; d.ctrl = 8'h12; d.imm = {{20{i[31]}}, i[31:25], i[11:7]};
            end
            7'h13: begin
                d.ctrl = 8'h03; d.imm = {{20{i[31]}}, i[31:20]};
                if (f3 == 1) begin d.ill = (f7 != 0); d.alu = A_SLL; d.imm = shamt; end
                else if (f3 == 5) begin d.ill = !(f7 == 0 || f7 == 7'h20); d.alu = f7[5] ? A_SRA : A_SRL; d.imm = shamt; end
                else begin d.ill = 0; d.alu = (f3 == 0) ? A_ADDI : OP_ALU[f3]; end
            end
            7'h33: begin
                d.ctrl = 8'h01;
                if (f7 == 0) begin d.ill = 0; d.alu = OP_ALU[f3]; end
                else if (f7 == 7'h20) begin d.ill = !(f3 == 0 || f3 == 5); d.alu = (f3 == 0) ? A_SUB : A_SRA; end
                else if (f7 == 7'h01) begin
`ifdef DECODE_MEXT_EN
                    d.ill = !(f3 inside {0, 1, 4, 6});
                    d.alu = (f3 == 0) ? 4'd12 : (f3 == 1) ? 4'd13 : (f3 == 4) ? 4'd14 : 4'd15;
`endif
                end
            end
            default: ;
        endcase
        if (d.ill) begin d.alu = 0; d.ctrl = 0; d.imm = 0; d.fcs = 0; end
        return d;
    endfunction

    function automatic logic [31:0] addi_x1(input int k);
        logic [31:0] w;
        w = {k[11:0], 20'h00093};
        return w;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  opc, f7;
        int idx;
        r = $urandom;
        if ($urandom_range(0, 9) == 0) return r;
        idx = $urandom_range(0, 11);
        if (idx > 8) idx = 7 + (idx % 2);
        opc = OPCS[idx];
        if ((opc == 7'h6F || opc == 7'h67) && $urandom_range(0, 3) != 0) opc = 7'h33;
        case ($urandom_range(0, 3))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            2: f7 = 7'h01;
            default: f7 = r[31:25];
        endcase
        return {f7, r[24:7], opc};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic compare_model();
        dec_t d;
        logic [31:0] iw;
        chk("out_valid", out_valid, m_valid);
        chk("occupancy", occupancy, q.size());
        if (m_valid || m_zero) begin
            iw = m_zero ? 32'h0 : m_ent.instr;
            d  = m_zero ? dec_t'(0) : ref_decode(iw);
            chk("out_pc", out_pc, m_zero ? '0 : m_ent.pc);
            chk("opcode", opcode, iw[6:0]);
            chk("funct3", funct3, iw[14:12]);
            chk("funct7", funct7, iw[31:25]);
            chk("rs1", rs1, d.rs1);
            chk("rs2", rs2, iw[24:20]);
            chk("rd", rd, iw[11:7]);
            chk("imm", imm, d.imm);
            chk("alu_op", alu_op, d.alu);
            chk("ctrl", ctrl, d.ctrl);
            chk("illegal", illegal, d.ill);
            chk("flush_cs", flush_cs, d.fcs);
        end
    endtask

    // Drive one cycle at the falling edge, advance the model, then compare after the next rising edge.
    task automatic cycle(input logic rn, input logic iv, input logic [31:0] ins,
                         input logic [XLEN-1:0] pc, input logic fl, input logic ordy);
        bit push, load;
        ent_t h;
        rst_n = rn; in_valid = iv; in_instr = ins; in_pc = pc; flush = fl; out_ready = ordy;
        #1;
        chk("in_ready", in_ready, rn && (q.size() < DEPTH));
        if (!rn) begin
            q.delete(); m_valid = 0; m_zero = 1; m_ent = '0;
        end else if (fl) begin
            q.delete(); m_valid = 0;
        end else begin
            push = iv && (q.size() < DEPTH);
            load = (q.size() > 0) && (!m_valid || ordy);
            if (load) begin
                h = q.pop_front();
                m_valid = 1; m_zero = 0; m_ent = h;
                if (ref_decode(h.instr).fcs) begin q.delete(); push = 0; end
            end else if (ordy) begin
                m_valid = 0;
            end
            if (push) q.push_back('{ins, pc});
        end
        @(posedge clk);
        @(negedge clk);
        compare_model();
        $display("cyc rst_n=%0b in_v=%0b instr=%08h flush=%0b ordy=%0b -> out_v=%0b pc=%08h occ=%0d",
                 rn, iv, ins, fl, ordy, out_valid, out_pc, occupancy);
    endtask

    initial begin
        dec_t dref;
        rst_n = 0; in_valid = 0; in_instr = 0; in_pc = 0; flush = 0; out_ready = 0;
        m_valid = 0; m_zero = 1; m_ent = '0;
        @(negedge clk);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'h00500093, 0, 0, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset occupancy", occupancy, 0);
        chk("reset imm", imm, 0);
        chk("reset ctrl", ctrl, 0);

        dref = ref_decode(32'h00500093);
        chk("model addi imm", dref.imm, 32'd5);
        chk("model addi ctrl", dref.ctrl, 8'h03);
        dref = ref_decode(32'hFE208EE3);
        chk("model beq imm", dref.imm, 32'hFFFFFFFC);

        // ADDI x1,x0,5 with two-cycle latency
        cycle(1, 1, 32'h00500093, 32'h100, 0, 1);
        chk("addi latency", out_valid, 0);
        cycle(1, 0, 0, 0, 0, 1);
        chk("addi valid", out_valid, 1);
        chk("addi rd", rd, 1);
        chk("addi imm", imm, 5);
        chk("addi alu", alu_op, A_ADDI);
        chk("addi ctrl", ctrl, 8'h03);
        cycle(1, 0, 0, 0, 0, 1);

        // Back-pressure: fill queue plus output register, then drain in order
        for (int k = 1; k <= 5; k++) cycle(1, 1, addi_x1(k), 32'h200 + 4 * k, 0, 0);
        chk("full occupancy", occupancy, 4);
        chk("full in_ready", in_ready, 0);
        cycle(1, 1, addi_x1(9), 32'h2F0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            chk("drain order imm", imm, k);
            cycle(1, 0, 0, 0, 0, 1);
        end
        chk("drained valid", out_valid, 0);

        // JAL self-flush discards the following ADDIs
        cycle(1, 1, 32'h008000EF, 32'h300, 0, 0);
        cycle(1, 1, addi_x1(7), 32'h304, 0, 0);
        chk("jal flush_cs", flush_cs, 1);
        chk("jal imm", imm, 8);
        chk("jal ctrl", ctrl, 8'h41);
        chk("jal occupancy", occupancy, 0);
        chk("jal pc", out_pc, 32'h300);
        cycle(1, 1, addi_x1(7), 32'h308, 1, 0);
        chk("redirect valid", out_valid, 0);

        // External flush with three queued entries and a concurrent push
        for (int k = 1; k <= 4; k++) cycle(1, 1, addi_x1(k + 20), 32'h400 + 4 * k, 0, 0);
        chk("pre-flush occupancy", occupancy, 3);
        cycle(1, 1, addi_x1(30), 32'h420, 1, 0);
        chk("flush valid", out_valid, 0);
        chk("flush occupancy", occupancy, 0);
        cycle(1, 0, 0, 0, 0, 1);
        chk("flush push dropped", out_valid, 0);

        // Branch, store and multiply encodings
        cycle(1, 1, 32'hFE208EE3, 32'h500, 0, 1);
        cycle(1, 1, 32'h0020A423, 32'h504, 0, 1);
        chk("beq imm", imm, 32'hFFFFFFFC);
        chk("beq ctrl", ctrl, 8'h20);
        cycle(1, 1, 32'h022081B3, 32'h508, 0, 1);
        chk("sw imm", imm, 8);
        chk("sw ctrl", ctrl, 8'h12);
        cycle(1, 0, 0, 0, 0, 1);
`ifdef DECODE_MEXT_EN
        chk("mul alu", alu_op, 4'd12);
        chk("mul illegal", illegal, 0);
`else
        chk("mul illegal", illegal, 1);
        chk("mul ctrl", ctrl, 0);
`endif
        cycle(1, 0, 0, 0, 0, 1);

        // Randomized traffic: alternating phases of heavy and light back-pressure
        for (int n = 0; n < 3000; n++) begin
            logic rn, fl, iv, ordy;
            rn   = ($urandom_range(0, 199) != 0);
            fl   = ($urandom_range(0, 49) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ((n / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cycle(rn, iv, rand_instr(), $urandom, fl, ordy);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
